ysyx_23060332_ifu: RTL and testbench
====================================

# ysyx_23060332_ifu

Instruction fetch unit for the ysyx_23060332 core. Accepts a fetch address from the PC stage, runs one request/response transaction on the instruction-memory port, and presents the returned instruction with its address to the decode stage (`ysyx_23060332_idu`) under a valid/ready handshake. At most one fetch is outstanding. Redirects abandon or drain the in-flight fetch through a flush input.

## Interface
- `ADDR_W`, default 32: fetch address width.
- `INST_W`, default 32: instruction width.
- `NOP_INST`, default 32'h00000013: instruction substituted on a faulting fetch.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `pc`  in  ADDR_W  fetch address from the PC stage.
- `pc_valid`  in  1  `pc` is valid.
- `pc_ready`  out  1  IFU accepts `pc` this cycle.
- `flush`  in  1  redirect; discard the current fetch.
- `imem_req_valid`  out  1  memory read request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  ADDR_W  request address.
- `imem_rsp_valid`  in  1  response data valid. Always accepted; there is no backpressure.
- `imem_rsp_data`  in  INST_W  returned instruction.
- `imem_rsp_err`  in  1  bus error on the response.
- `inst`  out  INST_W  instruction sent to decode.
- `inst_addr`  out  ADDR_W  address of `inst`.
- `inst_valid`  out  1  `inst` and `inst_addr` are valid.
- `inst_ready`  in  1  decode consumes the instruction.
- `fetch_err`  out  1  the held instruction is faulted; qualified by `inst_valid`.

## Operation
FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE
  - `pc_ready`=1.
  - On `pc_valid` && !`flush`: latch `pc` into `addr_q` and go to REQ.
- REQ
  - `imem_req_valid`=1 and `imem_req_addr`=`addr_q`.
  - On `imem_req_ready`: go to WAIT.
  - On `flush`: go to IDLE and withdraw the request. The memory port permits withdrawal before acceptance.
- WAIT
  - On `imem_rsp_valid`: capture data into `inst_q` and the error into `err_q`, then go to HOLD.
  - On `flush`: go to DRAIN. If `imem_rsp_valid` is set in the same cycle, the response is dropped and the FSM goes to IDLE.
- DRAIN: on `imem_rsp_valid`, discard the response and go to IDLE. `pc_ready`=0.
- HOLD
  - `inst_valid`=1, `inst`=`inst_q`, `inst_addr`=`addr_q`, `fetch_err`=`err_q`.
  - On `inst_ready`: go to IDLE.
  - On `flush`: go to IDLE and drop the instruction.
- Priority: `flush` overrides every other event in the same cycle.
- When `err_q`=1, `inst` is forced to `NOP_INST`.
- `addr_q`, `inst_q` and `err_q` change only on their capture events.

## Timing
- Reset, asynchronous:
  - state=IDLE.
  - `addr_q`=0, `inst_q`=`NOP_INST`, `err_q`=0.
  - `imem_req_valid`=0, `inst_valid`=0, `fetch_err`=0.
  - `pc_ready`=1 from the first cycle after `rst` deasserts.
- `pc_ready` and `imem_req_valid` are decoded from state only; there is no combinational path from `pc_valid`.
- Minimum latency with zero-wait memory:
  - PC accepted at cycle N.
  - Request accepted at N+1.
  - Response at N+2 or later; a response never arrives in the same cycle as its request handshake.
  - `inst_valid` at N+3.
- Throughput: one instruction per 4 cycles at best. The next PC is accepted only in the cycle after the HOLD handshake.
- `imem_req_addr` is stable while `imem_req_valid`=1 and no flush occurs.
- Reset mid-transaction returns to IDLE immediately. The memory side must also be reset; no drain occurs.

## Configuration
Macro `YSYX_23060332_IFU_MISALIGN_CHK_EN`.
- Defined: in IDLE, accepting a `pc` with `pc[1:0]`!=0 issues no memory request. The FSM goes straight to HOLD with `err_q`=1 and `inst`=`NOP_INST`, so `inst_valid` is asserted one cycle after acceptance.
- Undefined: no check. `imem_req_addr` is `{addr_q[ADDR_W-1:2],2'b00}`, and `inst_addr` reports the unmodified `addr_q`.

## Structure
- Shared package/define file (`ysyx_23060332_define.v`) holds:
  - The state encoding localparams (IFU_IDLE..IFU_DRAIN, 3 bits).
  - `NOP_INST`.
  - The existing `InstBus`/`InstAddrBus` widths.
- No sub-module. A single FSM module with output registers is sufficient.
- The top instantiates the IFU between `ysyx_23060332_pc` and `ysyx_23060332_idu`.

## Test plan
- Zero-wait memory, `pc`=0x80000000, rsp data 0x00100093 → `inst_valid` at cycle 3 after acceptance with `inst`=0x00100093, `inst_addr`=0x80000000, `fetch_err`=0.
- `imem_req_ready` held low 3 cycles, `inst_ready` low 2 cycles → `imem_req_addr` stable throughout the stall, the instruction is held unchanged, and `pc_ready` stays 0 until the HOLD handshake.
- `flush` in WAIT, rsp 0xDEADBEEF arriving 2 cycles later → no `inst_valid` and the response is discarded. A new `pc`=0x80000010 fetches correctly afterwards.
- `imem_rsp_err`=1 → `fetch_err`=1 and `inst`=0x00000013.
- Macro defined, `pc`=0x80000002 → no `imem_req_valid`, `inst_valid`=1 next cycle with `fetch_err`=1. Macro undefined → `imem_req_addr`=0x80000000.
- Assert `rst` during WAIT → all outputs return to their reset values asynchronously, and the FSM is in IDLE once `rst` deasserts.

Source files
------------

// File: rtl/ysyx_23060332_ifu_pkg.sv
// ysyx_23060332_ifu_pkg: shared definitions for the instruction fetch unit.
// Holds the instruction/address bus widths, the FSM state encoding and the
// instruction substituted for a faulting fetch.
package ysyx_23060332_ifu_pkg;

  // Existing core bus widths (InstBus / InstAddrBus).
  localparam int INST_BUS_W      = 32;
  localparam int INST_ADDR_BUS_W = 32;

  // addi x0, x0, 0 -- handed to decode in place of a faulted instruction.
  localparam logic [INST_BUS_W-1:0] IFU_NOP_INST = 32'h0000_0013;

  localparam int IFU_STATE_W = 3;

  // IFU_IDLE..IFU_DRAIN.
  typedef enum logic [IFU_STATE_W-1:0] {
    IFU_IDLE  = 3'd0,
    IFU_REQ   = 3'd1,
    IFU_WAIT  = 3'd2,
    IFU_HOLD  = 3'd3,
    IFU_DRAIN = 3'd4
  } ifu_state_e;

  // A fetch address is misaligned when it is not on a 4-byte boundary.
  function automatic logic ifu_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// ysyx_23060332_ifu_if: the IFU's three handshake channels bundled together:
// PC stage -> IFU, IFU <-> instruction memory, IFU -> decode.
// The master modport is the IFU's view; the slave modport is the view of the
// surrounding blocks (PC stage, memory, decode, or a testbench).
interface ysyx_23060332_ifu_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);

  // PC stage channel
  logic [ADDR_W-1:0] pc;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;

  // Instruction memory channel
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              imem_rsp_err;

  // Decode channel
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_valid;
  logic              inst_ready;
  logic              fetch_err;

  modport master (
    input  pc, pc_valid, flush,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_ready,
    output pc_ready,
    output imem_req_valid, imem_req_addr,
    output inst, inst_addr, inst_valid, fetch_err
  );

  modport slave (
    output pc, pc_valid, flush,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_ready,
    input  pc_ready,
    input  imem_req_valid, imem_req_addr,
    input  inst, inst_addr, inst_valid, fetch_err
  );

endinterface

// File: rtl/ysyx_23060332_ifu.sv
// ysyx_23060332_ifu: instruction fetch unit.
// Takes one fetch address from the PC stage, runs a single request/response
// transaction on the instruction-memory port and holds the result for decode
// under a valid/ready handshake. At most one fetch is ever outstanding; flush
// abandons the fetch, draining a response that is already owed by memory.
//
// Build option: define YSYX_23060332_IFU_MISALIGN_CHK_EN to reject fetch
// addresses that are not word aligned. Such a fetch issues no memory request
// and goes straight to decode as a faulted NOP one cycle after acceptance.
// Without the macro the low address bits are simply masked on the memory
// request while decode still sees the address as supplied.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter logic [INST_W-1:0] NOP_INST = IFU_NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_23060332_ifu_if.master bus
);

  // FSM state and the fetch context it carries
  ifu_state_e        state_r;
  ifu_state_e        state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_s;
  logic [INST_W-1:0] inst_buf_r;
  logic [INST_W-1:0] inst_buf_s;
  logic              err_r;
  logic              err_s;

  // Output registers, loaded from the next-state values so every port is a
  // flop output and nothing reaches a port combinationally from an input.
  logic              pc_ready_r;
  logic              req_valid_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic              inst_valid_r;
  logic [INST_W-1:0] inst_out_r;
  logic              fetch_err_r;

  // Next-state and capture decisions; flush outranks every other event.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    inst_buf_s = inst_buf_r;
    err_s      = err_r;

    case (state_r)
      IFU_IDLE: begin
        if (bus.pc_valid && !bus.flush) begin
          addr_s = bus.pc;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
          if (ifu_misaligned(bus.pc[1:0])) begin
            // No bus traffic for a misaligned fetch: report it as a fault.
            state_s = IFU_HOLD;
            err_s   = 1'b1;
          end else begin
            state_s = IFU_REQ;
          end
`else
          state_s = IFU_REQ;
`endif
        end else begin
          state_s = IFU_IDLE;
        end
      end

      IFU_REQ: begin
        if (bus.flush) begin
          // The request has not been accepted yet, so it can be withdrawn.
          state_s = IFU_IDLE;
        end else if (bus.imem_req_ready) begin
          state_s = IFU_WAIT;
        end else begin
          state_s = IFU_REQ;
        end
      end

      IFU_WAIT: begin
        if (bus.flush) begin
          // A response already on the bus is dropped now; otherwise one is
          // still owed and must be swallowed before the next request.
          if (bus.imem_rsp_valid) begin
            state_s = IFU_IDLE;
          end else begin
            state_s = IFU_DRAIN;
          end
        end else if (bus.imem_rsp_valid) begin
          inst_buf_s = bus.imem_rsp_data;
          err_s      = bus.imem_rsp_err;
          state_s    = IFU_HOLD;
        end else begin
          state_s = IFU_WAIT;
        end
      end

      IFU_DRAIN: begin
        // A flush here changes nothing: the owed response must still arrive.
        if (bus.imem_rsp_valid) begin
          state_s = IFU_IDLE;
        end else begin
          state_s = IFU_DRAIN;
        end
      end

      IFU_HOLD: begin
        if (bus.flush || bus.inst_ready) begin
          state_s = IFU_IDLE;
        end else begin
          state_s = IFU_HOLD;
        end
      end

      default: begin
        state_s = IFU_IDLE;
      end
    endcase
  end

  // FSM state and fetch context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IFU_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      inst_buf_r <= NOP_INST;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      inst_buf_r <= inst_buf_s;
      err_r      <= err_s;
    end
  end

  // Port registers, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_ready_r   <= 1'b1;
      req_valid_r  <= 1'b0;
      req_addr_r   <= {ADDR_W{1'b0}};
      inst_valid_r <= 1'b0;
      inst_out_r   <= NOP_INST;
      fetch_err_r  <= 1'b0;
    end else begin
      pc_ready_r   <= (state_s == IFU_IDLE);
      req_valid_r  <= (state_s == IFU_REQ);
      req_addr_r   <= {addr_s[ADDR_W-1:2], 2'b00};
      inst_valid_r <= (state_s == IFU_HOLD);
      inst_out_r   <= err_s ? NOP_INST : inst_buf_s;
      fetch_err_r  <= err_s;
    end
  end

  assign bus.pc_ready       = pc_ready_r;
  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_req_addr  = req_addr_r;
  assign bus.inst_valid     = inst_valid_r;
  assign bus.inst           = inst_out_r;
  assign bus.inst_addr      = addr_r;
  assign bus.fetch_err      = fetch_err_r;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// tb_ysyx_23060332_ifu: scoreboard bench for the instruction fetch unit.
// The driver plays PC stage, memory and decode. For each fetch it chooses
// what should happen (complete, or be flushed in some phase) and, for a
// completing fetch, pushes the instruction decode must receive. A separate
// monitor pops and compares on every decode handshake.
`timescale 1ns/1ps
module tb_ysyx_23060332_ifu;
  import ysyx_23060332_ifu_pkg::*;

  localparam int          AW  = 32;
  localparam int          IW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // fetch outcomes chosen by the driver
  localparam int M_DONE       = 0;
  localparam int M_FLUSH_REQ  = 1;
  localparam int M_FLUSH_WAIT = 2;
  localparam int M_FLUSH_RSP  = 3;
  localparam int M_FLUSH_HOLD = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ysyx_23060332_ifu_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  ysyx_23060332_ifu #(.ADDR_W(AW), .INST_W(IW), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: inputs are driven at the falling edge, so 2ns later both the
  // outputs and the decode-side ready are settled for the next rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.inst_valid && bus.inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_inst: handshake inst=0x%08h addr=0x%08h, expected no instruction",
                   bus.inst, bus.inst_addr);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst", bus.inst, e.inst);
          check("sb_inst_addr", bus.inst_addr, e.addr);
          check("sb_fetch_err", {31'd0, bus.fetch_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // HOLD phase: decode stalls, then either consumes or the fetch is flushed.
  task automatic hold_phase(input int rdy_stall, input int mode,
                            input logic [31:0] x_inst, input logic [31:0] x_addr,
                            input logic x_err);
    check("inst_valid_on_entry", {31'd0, bus.inst_valid}, 32'd1);
    check("hold_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
    for (int i = 0; i < rdy_stall; i++) begin
      bus.inst_ready = 1'b0;
      tick();
      check("hold_inst_valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hold_inst", bus.inst, x_inst);
      check("hold_inst_addr", bus.inst_addr, x_addr);
      check("hold_fetch_err", {31'd0, bus.fetch_err}, {31'd0, x_err});
      check("hold_pc_ready_stall", {31'd0, bus.pc_ready}, 32'd0);
    end
    if (mode == M_FLUSH_HOLD) begin
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
    end else begin
      bus.inst_ready = 1'b1;
      tick();
      bus.inst_ready = 1'b0;
    end
    check("post_hold_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("post_hold_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
  endtask

  // One fetch from PC acceptance to return to IDLE.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input logic e,
                          input int req_stall, input int rsp_dly, input int rdy_stall,
                          input int mode_in);
    logic [31:0] req_a;
    logic [31:0] x_inst;
    logic        x_err;
    logic        mis;
    int          mode;
    int          t;
    exp_t        ev;

    mode  = mode_in;
    req_a = {a[31:2], 2'b00};
    mis   = 1'b0;
`ifdef YSYX_23060332_IFU_MISALIGN_CHK_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (mis && mode != M_FLUSH_HOLD) mode = M_DONE;
    x_err  = mis | e;
    x_inst = x_err ? NOP : d;

    t = 0;
    while (!bus.pc_ready && t < 20) begin
      tick();
      t++;
    end
    check("pc_ready_before_issue", {31'd0, bus.pc_ready}, 32'd1);

    bus.pc       = a;
    bus.pc_valid = 1'b1;
    if (mode == M_DONE) begin
      ev.inst = x_inst;
      ev.addr = a;
      ev.err  = x_err;
      exp_q.push_back(ev);
    end
    tick();
    bus.pc_valid = 1'b0;
    bus.pc       = $urandom();

    if (mis) begin
      check("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
      hold_phase(rdy_stall, mode, x_inst, a, x_err);
      return;
    end

    // REQ
    check("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    check("req_addr", bus.imem_req_addr, req_a);
    check("req_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
    check("req_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    if (mode == M_FLUSH_REQ) begin
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("req_withdrawn", {31'd0, bus.imem_req_valid}, 32'd0);
      check("req_flush_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
      return;
    end
    for (int i = 0; i < req_stall; i++) begin
      tick();
      check("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
      check("stall_req_addr", bus.imem_req_addr, req_a);
      check("stall_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
    end
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;

    // WAIT
    check("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    if (mode == M_FLUSH_RSP) begin
      bus.flush          = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = d;
      bus.imem_rsp_err   = e;
      tick();
      bus.flush          = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      check("flush_rsp_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
      check("flush_rsp_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      return;
    end
    if (mode == M_FLUSH_WAIT) begin
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      for (int i = 0; i < rsp_dly; i++) begin
        check("drain_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
        check("drain_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
      end
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = d;
      bus.imem_rsp_err   = e;
      tick();
      bus.imem_rsp_valid = 1'b0;
      check("drained_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
      check("drained_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      return;
    end
    for (int i = 0; i < rsp_dly; i++) begin
      check("wait_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      check("wait_pc_ready", {31'd0, bus.pc_ready}, 32'd0);
      bus.imem_rsp_data = $urandom();
      tick();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = d;
    bus.imem_rsp_err   = e;
    tick();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom();
    bus.imem_rsp_err   = 1'($urandom_range(0, 1));

    hold_phase(rdy_stall, mode, x_inst, a, x_err);
  endtask

  initial begin : driver
    logic [31:0] ra;
    logic [31:0] rd;
    logic        re;
    int          sel;
    int          mode;

    rst                = 1'b1;
    bus.pc             = 32'd0;
    bus.pc_valid       = 1'b0;
    bus.flush          = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
    check("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    check("rst_inst", bus.inst, NOP);
    check("rst_inst_addr", bus.inst_addr, 32'd0);

    // directed cases
    do_fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 0, M_DONE);
    do_fetch(32'h8000_0004, 32'h0020_0113, 1'b0, 3, 0, 2, M_DONE);
    do_fetch(32'h8000_0008, 32'hDEAD_BEEF, 1'b0, 0, 1, 0, M_FLUSH_WAIT);
    do_fetch(32'h8000_0010, 32'h0030_0193, 1'b0, 0, 1, 0, M_DONE);
    do_fetch(32'h8000_0014, 32'h1234_5678, 1'b1, 1, 2, 1, M_DONE);
    do_fetch(32'h8000_0002, 32'h0040_0213, 1'b0, 0, 0, 0, M_DONE);
    do_fetch(32'h8000_0018, 32'h0050_0293, 1'b0, 2, 0, 0, M_FLUSH_REQ);
    do_fetch(32'h8000_001C, 32'h0060_0313, 1'b0, 0, 1, 0, M_FLUSH_RSP);
    do_fetch(32'h8000_0020, 32'h0070_0393, 1'b1, 0, 0, 2, M_FLUSH_HOLD);

    // randomized fetches
    for (int n = 0; n < 200; n++) begin
      ra  = $urandom();
      rd  = $urandom();
      re  = ($urandom_range(0, 4) == 0);
      sel = $urandom_range(0, 9);
      if (sel <= 5)      mode = M_DONE;
      else if (sel == 6) mode = M_FLUSH_REQ;
      else if (sel == 7) mode = M_FLUSH_WAIT;
      else if (sel == 8) mode = M_FLUSH_RSP;
      else               mode = M_FLUSH_HOLD;
      do_fetch(ra, rd, re, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), mode);
    end

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // reset while a fetch is waiting for its response
    do_fetch(32'h8000_0030, 32'h0080_0413, 1'b0, 0, 0, 0, M_DONE);
    bus.pc       = 32'h8000_0040;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid       = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("arst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    check("arst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    check("arst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
    check("arst_inst", bus.inst, NOP);
    check("arst_inst_addr", bus.inst_addr, 32'd0);
    check("arst_req_addr", bus.imem_req_addr, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_arst_pc_ready", {31'd0, bus.pc_ready}, 32'd1);
    check("post_arst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    do_fetch(32'h8000_0044, 32'h0090_0493, 1'b0, 0, 0, 0, M_DONE);

    repeat (2) tick();
    check("final_scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
